// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller and exception redirect unit.
// Define PIPE_CTRL_EXC_DRAIN_EN to hold exceptions until the data bus drains.
module pipe_ctrl #(
    parameter int unsigned NSTAGE      = 5,
    parameter int unsigned DRAIN_TO    = 255,
    parameter logic [31:0] NORMAL_BASE = 32'h8000_0000,
    parameter logic [31:0] BOOT_BASE   = 32'hBFC0_0200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] streq,
    input  logic [NSTAGE-1:0] stage_null,
    input  logic              exc_flag,
    input  logic [1:0]        exc_class,
    input  logic              bev,
    input  logic              exl,
    input  logic              erl,
    input  logic              iv,
    input  logic [31:0]       epc,
    input  logic [31:0]       errorepc,
    input  logic              bus_busy,
    output logic [NSTAGE-1:0] stall,
    output logic [NSTAGE-1:0] flush,
    output logic [31:0]       flush_pc,
    output logic              drain_timeout
);

    logic [31:0]       base;
    logic [31:0]       target;
    logic [NSTAGE-1:0] chain_stall;
    logic [NSTAGE-1:0] chain_flush;

    always_comb begin
        base = bev ? BOOT_BASE : NORMAL_BASE;
        case (exc_class)
            2'd1:    target = iv ? base + 32'h200 : base + 32'h180;
            2'd2:    target = exl ? base + 32'h180 : base;
            2'd3:    target = erl ? errorepc : epc;
            default: target = base + 32'h180;
        endcase
    end

    // A stall propagates upstream until it meets a bubble; IF always follows ID.
    always_comb begin
        chain_stall = '0;
        chain_stall[NSTAGE-1] = streq[NSTAGE-1];
        for (int i = NSTAGE - 2; i >= 1; i--) begin
            chain_stall[i] = streq[i] | (chain_stall[i+1] & ~stage_null[i]);
        end
        chain_stall[0] = streq[0] | chain_stall[1];
        chain_flush = '0;
        for (int i = 1; i < NSTAGE; i++) begin
            chain_flush[i] = chain_stall[i-1] & ~chain_stall[i];
        end
    end

    logic unused_null;
    assign unused_null = stage_null[0] ^ stage_null[NSTAGE-1];

`ifdef PIPE_CTRL_EXC_DRAIN_EN
    typedef enum logic [1:0] {StRun, StDrain, StRedir} state_e;

    localparam logic [8:0] DrainLim = 9'(DRAIN_TO);

    state_e      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        to_q, to_d;
    logic [8:0]  cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            tgt_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        cnt_d         = cnt_q;
        to_d          = to_q;
        stall         = chain_stall;
        flush         = chain_flush;
        flush_pc      = '0;
        drain_timeout = 1'b0;
        cnt_inc       = {1'b0, cnt_q} + 9'd1;

        case (state_q)
            StRun: begin
                if (exc_flag) begin
                    if (bus_busy) begin
                        stall   = '1;
                        flush   = '0;
                        tgt_d   = target;
                        cnt_d   = '0;
                        to_d    = 1'b0;
                        state_d = StDrain;
                    end else begin
                        stall    = '0;
                        flush    = '1;
                        flush_pc = target;
                    end
                end
            end
            StDrain: begin
                stall = '1;
                flush = '0;
                // Saturate so the counter can never wrap while draining.
                cnt_d = (cnt_inc >= DrainLim) ? DrainLim[7:0] : cnt_inc[7:0];
                if (!bus_busy) begin
                    state_d = StRedir;
                    to_d    = 1'b0;
                end else if (cnt_inc >= DrainLim) begin
                    state_d = StRedir;
                    to_d    = 1'b1;
                end
            end
            StRedir: begin
                stall         = '0;
                flush         = '1;
                flush_pc      = tgt_q;
                drain_timeout = to_q;
                state_d       = StRun;
            end
            default: state_d = StRun;
        endcase

        if (rst) begin
            stall         = '0;
            flush         = '0;
            flush_pc      = '0;
            drain_timeout = 1'b0;
        end
    end
`else
    always_comb begin
        stall    = chain_stall;
        flush    = chain_flush;
        flush_pc = '0;
        if (exc_flag) begin
            stall    = '0;
            flush    = '1;
            flush_pc = target;
        end
        if (rst) begin
            stall    = '0;
            flush    = '0;
            flush_pc = '0;
        end
    end

    assign drain_timeout = 1'b0;

    logic unused_cfg;
    assign unused_cfg = clk ^ bus_busy ^ (DRAIN_TO == 0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed cases then randomized traffic
// against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int unsigned N       = 5;
    localparam int unsigned DrainTo = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  streq;
    logic [N-1:0]  stage_null;
    logic          exc_flag;
    logic [1:0]    exc_class;
    logic          bev, exl, erl, iv;
    logic [31:0]   epc, errorepc;
    logic          bus_busy;
    logic [N-1:0]  stall;
    logic [N-1:0]  flush;
    logic [31:0]   flush_pc;
    logic          drain_timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Outputs sampled in the most recent cycle.
    logic [N-1:0] s_stall, s_flush;
    logic [31:0]  s_pc;
    logic         s_to;

    // Reference model state: exception waiting for the bus, and pending redirect.
    bit          m_drain;
    bit          m_redir;
    bit          m_to;
    int          m_n;
    logic [31:0] m_tgt;

    pipe_ctrl #(
        .NSTAGE     (N),
        .DRAIN_TO   (DrainTo),
        .NORMAL_BASE(32'h8000_0000),
        .BOOT_BASE  (32'hBFC0_0200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .streq        (streq),
        .stage_null   (stage_null),
        .exc_flag     (exc_flag),
        .exc_class    (exc_class),
        .bev          (bev),
        .exl          (exl),
        .erl          (erl),
        .iv           (iv),
        .epc          (epc),
        .errorepc     (errorepc),
        .bus_busy     (bus_busy),
        .stall        (stall),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .drain_timeout(drain_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Stage i holds if some stage j>=i requests a stall and no bubble lies in
    // stages max(i,1)..j-1 to absorb it.
    function automatic void ref_chain(input logic [N-1:0] rq, input logic [N-1:0] nl,
                                      output logic [N-1:0] st, output logic [N-1:0] fl);
        for (int i = 0; i < N; i++) begin
            st[i] = 1'b0;
            for (int j = i; j < N; j++) begin
                if (rq[j]) begin
                    bit blocked = 0;
                    for (int k = i; k < j; k++) if (k >= 1 && nl[k]) blocked = 1;
                    if (!blocked) st[i] = 1'b1;
                end
            end
        end
        fl[0] = 1'b0;
        for (int i = 1; i < N; i++) fl[i] = st[i-1] & ~st[i];
    endfunction

    function automatic logic [31:0] ref_target();
        int unsigned b = bev ? 32'hBFC0_0200 : 32'h8000_0000;
        case (exc_class)
            2'd1:    return iv ? b + 512 : b + 384;
            2'd2:    return exl ? b + 384 : b;
            2'd3:    return erl ? errorepc : epc;
            default: return b + 384;
        endcase
    endfunction

    // Inputs are already applied; sample at the falling edge, compare, advance model.
    task automatic run_cycle();
        logic [N-1:0] es, ef;
        logic [31:0]  ep;
        logic         et;
        @(negedge clk);
        ref_chain(streq, stage_null, es, ef);
        ep = '0;
        et = 1'b0;
        if (rst) begin
            es = '0; ef = '0;
            m_drain = 0; m_redir = 0;
        end else if (m_redir) begin
            es = '0; ef = '1; ep = m_tgt; et = m_to;
            m_redir = 0;
        end else if (m_drain) begin
            es = '1; ef = '0;
            m_n++;
            if (!bus_busy) begin
                m_drain = 0; m_redir = 1; m_to = 0;
            end else if (m_n >= int'(DrainTo)) begin
                m_drain = 0; m_redir = 1; m_to = 1;
            end
        end else if (exc_flag) begin
`ifdef PIPE_CTRL_EXC_DRAIN_EN
            if (bus_busy) begin
                es = '1; ef = '0;
                m_drain = 1; m_n = 0; m_tgt = ref_target();
            end else begin
                es = '0; ef = '1; ep = ref_target();
            end
`else
            es = '0; ef = '1; ep = ref_target();
`endif
        end
        s_stall = stall; s_flush = flush; s_pc = flush_pc; s_to = drain_timeout;
        check("stall", 32'(stall), 32'(es));
        check("flush", 32'(flush), 32'(ef));
        check("flush_pc", flush_pc, ep);
        check("drain_timeout", 32'(drain_timeout), 32'(et));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        streq = '0; stage_null = '0; exc_flag = 0; exc_class = 0;
        bev = 0; exl = 0; erl = 0; iv = 0; epc = 0; errorepc = 0; bus_busy = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_drain = 0; m_redir = 0; m_to = 0; m_n = 0; m_tgt = '0;
        streq = 5'b10101;
        exc_flag = 1'b1;
        run_cycle();
        check("rst_stall", 32'(s_stall), 32'h0);
        check("rst_flush", 32'(s_flush), 32'h0);
        idle_inputs();
        run_cycle();
        rst = 1'b0;

        // Stall chain, no bubbles.
        streq = 5'b00100;
        run_cycle();
        check("tp_ex_stall", 32'(s_stall), 32'h07);
        check("tp_ex_flush", 32'(s_flush), 32'h08);

        // Bubble in EX absorbs the MEM stall.
        streq = 5'b01000; stage_null = 5'b00100;
        run_cycle();
        check("tp_mem_stall", 32'(s_stall), 32'h08);
        check("tp_mem_flush", 32'(s_flush), 32'h10);

        // Interrupt with IV, no drain.
        idle_inputs();
        exc_flag = 1; exc_class = 2'd1; iv = 1;
        run_cycle();
        check("tp_intr_flush", 32'(s_flush), 32'h1F);
        check("tp_intr_pc", s_pc, 32'h8000_0200);
        idle_inputs();
        run_cycle();

`ifdef PIPE_CTRL_EXC_DRAIN_EN
        // ERET with bus busy for three cycles.
        exc_flag = 1; exc_class = 2'd3; erl = 1; errorepc = 32'hBFC0_1000; bus_busy = 1;
        run_cycle();
        check("tp_drain_stall0", 32'(s_stall), 32'h1F);
        exc_flag = 0;
        for (int c = 1; c < 4; c++) begin
            bus_busy = (c < 3);
            run_cycle();
            check("tp_drain_stall", 32'(s_stall), 32'h1F);
        end
        bus_busy = 0;
        run_cycle();
        check("tp_drain_flush", 32'(s_flush), 32'h1F);
        check("tp_drain_pc", s_pc, 32'hBFC0_1000);

        // Bus stuck busy: forced flush after DrainTo+1 cycles.
        idle_inputs();
        exc_flag = 1; bus_busy = 1;
        run_cycle();
        exc_flag = 0;
        for (int c = 1; c <= int'(DrainTo); c++) run_cycle();
        check("tp_to_stall_last", 32'(s_stall), 32'h1F);
        run_cycle();
        check("tp_to_flush", 32'(s_flush), 32'h1F);
        check("tp_to_pulse", 32'(s_to), 32'h1);
        check("tp_to_pc", s_pc, 32'h8000_0180);
        run_cycle();
        check("tp_to_pulse_end", 32'(s_to), 32'h0);

        // Reset in the second drain cycle cancels the redirect.
        idle_inputs();
        exc_flag = 1; bus_busy = 1;
        run_cycle();
        exc_flag = 0;
        run_cycle();
        rst = 1;
        run_cycle();
        rst = 0; bus_busy = 0;
        run_cycle();
        check("tp_rst_stall", 32'(s_stall), 32'h0);
        check("tp_rst_flush", 32'(s_flush), 32'h0);
        run_cycle();
        check("tp_rst_noredir", 32'(s_flush), 32'h0);
`else
        // Without the drain path a busy bus does not delay the redirect.
        exc_flag = 1; exc_class = 2'd2; exl = 0; bev = 1; bus_busy = 1;
        run_cycle();
        check("nodrain_flush", 32'(s_flush), 32'h1F);
        check("nodrain_pc", s_pc, 32'hBFC0_0200);
        check("nodrain_to", 32'(s_to), 32'h0);
`endif

        // Randomized traffic.
        idle_inputs();
        for (int c = 0; c < 600; c++) begin
            streq      = N'($urandom_range(0, 3) == 0 ? $urandom : 0);
            stage_null = N'($urandom);
            exc_flag   = ($urandom_range(0, 5) == 0);
            exc_class  = 2'($urandom);
            bev = 1'($urandom); exl = 1'($urandom); erl = 1'($urandom); iv = 1'($urandom);
            epc = $urandom; errorepc = $urandom;
            if ($urandom_range(0, 3) == 0) bus_busy = ~bus_busy;
            rst = ($urandom_range(0, 79) == 0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
